// File: rtl/seven_segment_pkg.sv
// Shared types for the segment scroll sequencer: FSM states and message entry layout.
// SCROLL_POINT_EN widens each entry to {point, nibble}.
package seven_segment_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SCROLL   = 2'd1,
        FINISHED = 2'd2
    } state_e;

    localparam int NIBBLE_W = 4;
    localparam logic [NIBBLE_W-1:0] BLANK_NIBBLE = 4'h0;

`ifdef SCROLL_POINT_EN
    typedef struct packed {
        logic                point;
        logic [NIBBLE_W-1:0] nibble;
    } entry_t;
`else
    typedef struct packed {
        logic [NIBBLE_W-1:0] nibble;
    } entry_t;
`endif

endpackage

// File: rtl/scroll_tick_divider.sv
// Free-running power-of-two divider; tick pulses for one clock every 2**SCROLL_DIVISIONS clocks.
// restart realigns the phase so the first tick lands exactly 2**SCROLL_DIVISIONS clocks later.
module scroll_tick_divider #(
    parameter int SCROLL_DIVISIONS = 24
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    logic [SCROLL_DIVISIONS-1:0] r_cnt;

    always_ff @(posedge clock) begin
        if (reset || restart) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = &r_cnt;

endmodule

// File: rtl/segment_scroll_sequencer.sv
// Message buffer plus scroll scheduler feeding a seven-segment controller's data/pointEnable.
// Optional SCROLL_POINT_EN stores a decimal point per entry; otherwise pointEnable is tied low.
module segment_scroll_sequencer
    import seven_segment_pkg::*;
#(
    parameter int NUM_DIGITS       = 4,
    parameter int DEPTH            = 16,
    parameter int SCROLL_DIVISIONS = 24
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           wrValid,
    input  logic [NIBBLE_W-1:0]            wrData,
    input  logic                           wrPoint,
    output logic                           wrReady,
    input  logic                           clear,
    input  logic                           start,
    input  logic                           loop,
    output logic [NIBBLE_W*NUM_DIGITS-1:0] data,
    output logic [NUM_DIGITS-1:0]          pointEnable,
    output logic [NUM_DIGITS-1:0]          digitBlank,
    output logic                           busy,
    output logic                           done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    state_e                         r_state, w_state_nxt;
    logic [CW-1:0]                  r_count, w_count_nxt, w_count_wr;
    logic [CW-1:0]                  r_pos, w_pos_nxt;
    logic                           r_done_evt, w_done_evt_nxt;
    logic                           w_wr_ready, w_wr_acc, w_start_eff, w_tick;
    entry_t                         r_mem [DEPTH];
    entry_t                         w_wr_entry;
    logic [CW-1:0]                  w_idx;
    logic [NIBBLE_W*NUM_DIGITS-1:0] w_frame_data, w_data_nxt;
    logic [NUM_DIGITS-1:0]          w_frame_pt, w_frame_blank, w_pt_nxt, w_blank_nxt;

    assign w_wr_ready  = (r_state != SCROLL) && (r_count < CW'(DEPTH));
    assign wrReady     = w_wr_ready;
    assign w_wr_acc    = wrValid && w_wr_ready;
    assign w_count_wr  = r_count + CW'(w_wr_acc);
    // A write landing in the same cycle counts toward the message a start sees.
    assign w_start_eff = start && !clear && (w_count_wr != '0);

`ifdef SCROLL_POINT_EN
    assign w_wr_entry = '{point: wrPoint, nibble: wrData};
`else
    logic w_unused_point;
    assign w_wr_entry     = '{nibble: wrData};
    assign w_unused_point = wrPoint;
`endif

    scroll_tick_divider #(
        .SCROLL_DIVISIONS(SCROLL_DIVISIONS)
    ) u_div (
        .clock  (clock),
        .reset  (reset),
        .restart(w_start_eff),
        .tick   (w_tick)
    );

    always_ff @(posedge clock) begin
        if (!reset && !clear && w_wr_acc) begin
            r_mem[r_count[AW-1:0]] <= w_wr_entry;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_pos      <= '0;
            r_done_evt <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_pos      <= w_pos_nxt;
            r_done_evt <= w_done_evt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_count_nxt    = r_count;
        w_pos_nxt      = r_pos;
        w_done_evt_nxt = 1'b0;
        if (clear) begin
            w_state_nxt = IDLE;
            w_count_nxt = '0;
            w_pos_nxt   = '0;
        end else begin
            w_count_nxt = w_count_wr;
            if (w_start_eff) begin
                w_state_nxt = SCROLL;
                w_pos_nxt   = '0;
            end else if (r_state == SCROLL && w_tick) begin
                if (r_pos + CW'(1) < r_count) begin
                    w_pos_nxt = r_pos + CW'(1);
                end else if (loop) begin
                    w_pos_nxt = '0;
                end else begin
                    w_state_nxt    = FINISHED;
                    w_done_evt_nxt = 1'b1;
                end
            end
        end
    end

    // Window select: digit k shows entry[pos + NUM_DIGITS-1-k]; past the message end it goes dark.
    always_comb begin
        w_frame_data  = '0;
        w_frame_pt    = '0;
        w_frame_blank = '1;
        w_idx         = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            w_idx = r_pos + CW'(NUM_DIGITS - 1 - k);
            if (w_idx < r_count) begin
                w_frame_data[k*NIBBLE_W +: NIBBLE_W] = r_mem[w_idx[AW-1:0]].nibble;
                w_frame_blank[k]                     = 1'b0;
`ifdef SCROLL_POINT_EN
                w_frame_pt[k]                        = r_mem[w_idx[AW-1:0]].point;
`endif
            end else begin
                w_frame_data[k*NIBBLE_W +: NIBBLE_W] = BLANK_NIBBLE;
            end
        end
    end

    always_comb begin
        w_data_nxt  = data;
        w_pt_nxt    = pointEnable;
        w_blank_nxt = digitBlank;
        unique case (r_state)
            IDLE: begin
                w_data_nxt  = '0;
                w_pt_nxt    = '0;
                w_blank_nxt = '1;
            end
            SCROLL: begin
                w_data_nxt  = w_frame_data;
                w_pt_nxt    = w_frame_pt;
                w_blank_nxt = w_frame_blank;
            end
            default: ;  // FINISHED freezes the last frame even as writes append
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            data        <= '0;
            pointEnable <= '0;
            digitBlank  <= '1;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            data        <= w_data_nxt;
            pointEnable <= w_pt_nxt;
            digitBlank  <= w_blank_nxt;
            busy        <= (r_state == SCROLL);
            done        <= r_done_evt;
        end
    end

endmodule

// File: tb/tb_segment_scroll_sequencer.sv
// Directed bench for segment_scroll_sequencer with a queue-based message model checked every cycle.
module tb_segment_scroll_sequencer;

    localparam int ND  = 4;
    localparam int DEP = 16;
    localparam int SD  = 3;
    localparam int PER = 1 << SD;

    logic            clock, reset, wrValid, wrPoint, wrReady, clear, start, loop, busy, done;
    logic [3:0]      wrData;
    logic [4*ND-1:0] data;
    logic [ND-1:0]   pointEnable, digitBlank;

    segment_scroll_sequencer #(
        .NUM_DIGITS(ND), .DEPTH(DEP), .SCROLL_DIVISIONS(SD)
    ) dut (
        .clock(clock), .reset(reset), .wrValid(wrValid), .wrData(wrData), .wrPoint(wrPoint),
        .wrReady(wrReady), .clear(clear), .start(start), .loop(loop), .data(data),
        .pointEnable(pointEnable), .digitBlank(digitBlank), .busy(busy), .done(done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: message as queues; phase 0 idle, 1 scrolling, 2 finished.
    int unsigned     m_nib[$];
    bit              m_pt[$];
    int              m_ph = 0, m_pos = 0, m_since = 0;
    bit              m_fin = 0;
    logic [4*ND-1:0] e_data;
    logic [ND-1:0]   e_pe, e_blank;
    logic            e_busy, e_done;

    always @(posedge clock) begin
        // Outputs reflect the model as it stood before this edge.
        if (reset) begin
            e_data = '0; e_pe = '0; e_blank = '1; e_busy = 0; e_done = 0;
        end else begin
            e_busy = (m_ph == 1);
            e_done = m_fin;
            if (m_ph == 0) begin
                e_data = '0; e_pe = '0; e_blank = '1;
            end else if (m_ph == 1) begin
                for (int k = 0; k < ND; k++) begin
                    int idx;
                    idx = m_pos + ND - 1 - k;
                    if (idx < m_nib.size()) begin
                        e_data[4*k +: 4] = m_nib[idx][3:0];
                        e_blank[k]       = 1'b0;
`ifdef SCROLL_POINT_EN
                        e_pe[k]          = m_pt[idx];
`else
                        e_pe[k]          = 1'b0;
`endif
                    end else begin
                        e_data[4*k +: 4] = 4'h0;
                        e_blank[k]       = 1'b1;
                        e_pe[k]          = 1'b0;
                    end
                end
            end
        end
        m_fin = 0;
        if (reset || clear) begin
            m_nib.delete(); m_pt.delete(); m_ph = 0; m_pos = 0;
        end else begin
            if (wrValid && m_ph != 1 && m_nib.size() < DEP) begin
                m_nib.push_back(wrData);
                m_pt.push_back(wrPoint);
            end
            if (start && m_nib.size() > 0) begin
                m_ph = 1; m_pos = 0; m_since = 0;
            end else if (m_ph == 1) begin
                m_since++;
                if (m_since % PER == 0) begin
                    if (m_pos < m_nib.size() - 1) m_pos++;
                    else if (loop) m_pos = 0;
                    else begin m_ph = 2; m_fin = 1; end
                end
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("data", data, e_data);
            chk("pointEnable", pointEnable, e_pe);
            chk("digitBlank", digitBlank, e_blank);
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            chk("wrReady", wrReady, (m_ph != 1) && (m_nib.size() < DEP));
        end
    end

    task automatic tk();
        @(posedge clock);
        #1;
    endtask

    logic [3:0] exp_pe;

    initial begin
        reset = 1; wrValid = 0; wrData = 0; wrPoint = 0; clear = 0; start = 0; loop = 0;
        tk();
        chk_en = 1;
        tk();
        reset = 0;
        tk();
        chk("rst_data", data, 16'h0);
        chk("rst_blank", digitBlank, 4'hF);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", wrReady, 1'b1);

        // Five-entry message, single pass; point on the second entry.
        for (int i = 1; i <= 5; i++) begin
            wrValid = 1; wrData = i[3:0]; wrPoint = (i == 2); tk();
        end
        wrValid = 0; wrPoint = 0;
        start = 1; loop = 0; tk();
        start = 0; tk();
        chk("f0_data", data, 16'h1234);
        chk("f0_blank", digitBlank, 4'h0);
        chk("f0_busy", busy, 1'b1);
`ifdef SCROLL_POINT_EN
        exp_pe = 4'b0100;
`else
        exp_pe = 4'b0000;
`endif
        chk("f0_point", pointEnable, exp_pe);
        repeat (PER) tk();
        chk("f1_data", data, 16'h2345);
        repeat (PER) tk();
        chk("f2_data", data, 16'h3450);
        chk("f2_blank", digitBlank, 4'b0001);
        repeat (PER) tk();
        chk("f3_data", data, 16'h4500);
        repeat (PER) tk();
        chk("f4_data", data, 16'h5000);
        chk("f4_blank", digitBlank, 4'b0111);
        repeat (PER) tk();
        chk("fin_done", done, 1'b1);
        chk("fin_busy", busy, 1'b0);
        chk("fin_data", data, 16'h5000);
        tk();
        chk("fin_done_pulse", done, 1'b0);
        chk("fin_frozen", data, 16'h5000);

        // Same message looping.
        loop = 1; start = 1; tk();
        start = 0; tk();
        chk("lp_f0", data, 16'h1234);
        repeat (4*PER) tk();
        chk("lp_f4", data, 16'h5000);
        repeat (PER) tk();
        chk("lp_wrap", data, 16'h1234);
        chk("lp_nodone", done, 1'b0);
        chk("lp_busy", busy, 1'b1);

        // clear beats start during SCROLL.
        clear = 1; start = 1; tk();
        clear = 0; start = 0; loop = 0;
        chk("clr_ready", wrReady, 1'b1);
        tk();
        chk("clr_busy", busy, 1'b0);
        chk("clr_blank", digitBlank, 4'hF);
        chk("clr_done", done, 1'b0);

        // start on an empty buffer is ignored.
        start = 1; tk();
        start = 0; tk();
        chk("empty_busy", busy, 1'b0);
        chk("empty_blank", digitBlank, 4'hF);

        // start with a same-cycle write: the new entry is the message.
        wrValid = 1; wrData = 4'h7; start = 1; tk();
        wrValid = 0; start = 0; tk();
        chk("sw_data", data, 16'h7000);
        chk("sw_blank", digitBlank, 4'b0111);
        chk("sw_busy", busy, 1'b1);
        clear = 1; tk();
        clear = 0; tk();

        // Fill to DEPTH; the 17th write is ignored.
        for (int i = 0; i < DEP; i++) begin
            wrValid = 1; wrData = i[3:0]; wrPoint = i[0]; tk();
        end
        chk("full_ready", wrReady, 1'b0);
        wrData = 4'hE; tk();
        wrValid = 0; wrPoint = 0;
        chk("full_ready2", wrReady, 1'b0);
        start = 1; tk();
        start = 0; tk();
        chk("full_f0", data, 16'h0123);
        repeat (15*PER) tk();
        chk("full_last", data, 16'hF000);
        chk("full_last_blank", digitBlank, 4'b0111);

        // Reset mid-scroll.
        clear = 1; tk();
        clear = 0;
        for (int i = 1; i <= 5; i++) begin
            wrValid = 1; wrData = i[3:0]; tk();
        end
        wrValid = 0; start = 1; tk();
        start = 0; repeat (3) tk();
        reset = 1; tk();
        chk("mid_rst_data", data, 16'h0);
        chk("mid_rst_blank", digitBlank, 4'hF);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_ready", wrReady, 1'b1);
        reset = 0;
        repeat (4) tk();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
